// File: rtl/inv_sub_bytes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_sub_bytes_pkg
// Description : Shared AES definitions for the inverse SubBytes block: byte and
//               128-bit state typedefs, the state byte count and the encoding
//               of the IDLE / BUSY / DONE controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_sub_bytes_pkg;

  // Number of bytes in one AES state.
  localparam int N_BYTES = 16;

  typedef logic [7:0]           byte_t;
  typedef logic [8*N_BYTES-1:0] state_t;

  // Controller state encoding, shared so every user agrees on the values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Width of a counter that indexes `count` groups (at least 1 bit).
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sub_bytes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox
// Description : FIPS-197 inverse S-box, purely combinational 256-entry table.
//               Exact inverse of the forward AES S-box for all 256 inputs.
// Ports       : in_byte  - byte to substitute
//               out_byte - InvSbox(in_byte)
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row r holds InvSbox(16*r + c) for c = 0..15.
  localparam logic [7:0] INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_TABLE[in_byte];

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module      : inv_sub_bytes
// Description : AES InvSubBytes over a 128-bit state with a valid/ready
//               handshake. The captured state is substituted in place, LANES
//               bytes per cycle, over N = 16/LANES BUSY cycles, then held in
//               DONE until the sink accepts it.
// Parameters  : LANES - bytes substituted per cycle (1, 2, 4, 8 or 16)
// Macros      : INV_SUB_BYTES_FULL_PARALLEL_EN - when defined, forces 16 lanes
//               so BUSY lasts a single cycle; handshake is unchanged.
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - in_data is presented
//               in_ready  - block can accept a state (IDLE)
//               in_data   - input state, byte i = in_data[8i+7:8i]
//               out_valid - out_data holds a result (DONE)
//               out_ready - sink accepts out_data
//               out_data  - state register (InvSubBytes result in DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_bytes
  import inv_sub_bytes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

`ifdef INV_SUB_BYTES_FULL_PARALLEL_EN
  localparam int L = N_BYTES;
`else
  localparam int L = LANES;
`endif
  localparam int N  = N_BYTES / L;
  localparam int CW = cnt_width(N);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]     fsm;
  logic [CW-1:0]  cnt;
  state_t         state_reg;
  state_t         state_nxt;
  logic [L*8-1:0] lane_in;
  logic [L*8-1:0] lane_out;
  logic           last_grp;

  assign last_grp = (cnt == CW'(N - 1));

  // Route group `cnt` of the state register onto the lanes: lane k sees
  // byte cnt*L + k.
  always_comb begin
    lane_in = '0;
    for (int g = 0; g < N; g++) begin
      if (cnt == CW'(g)) begin
        lane_in = state_reg[g*L*8 +: L*8];
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    inv_sbox u_inv_sbox (
      .in_byte  (lane_in[k*8 +: 8]),
      .out_byte (lane_out[k*8 +: 8])
    );
  end

  // Write the substituted group back in place; all other bytes hold.
  always_comb begin
    state_nxt = state_reg;
    for (int g = 0; g < N; g++) begin
      if (cnt == CW'(g)) begin
        state_nxt[g*L*8 +: L*8] = lane_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      state_reg <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= in_data;
            cnt       <= '0;
            fsm       <= S_BUSY;
          end
        end
        S_BUSY: begin
          state_reg <= state_nxt;
          if (last_grp) begin
            cnt <= '0;
            fsm <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: begin
          fsm <= S_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);
  assign out_data  = state_reg;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_inv_sub_bytes
// Description : Self-checking bench for inv_sub_bytes. The reference inverse
//               S-box is derived from GF(2^8) inversion plus the AES affine
//               map; a transaction-level model predicts in_ready, out_valid
//               and out_data every cycle. Honours
//               INV_SUB_BYTES_FULL_PARALLEL_EN (16 lanes, latency 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes;

`ifdef INV_SUB_BYTES_FULL_PARALLEL_EN
  localparam int LANES = 16;
`else
  localparam int LANES = 4;
`endif
  localparam int NG = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;

  inv_sub_bytes #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  // ---------------- reference S-boxes from field arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_tables();
    logic [7:0] x, inv, s;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (v != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[v] = s;
      inv_tab[s] = x;
    end
  endtask

  // State after the first g groups of LANES bytes have been substituted.
  function automatic logic [127:0] partial(input logic [127:0] s, input int g);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      if (i < g * LANES) r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_block(input logic [127:0] s);
    return partial(s, NG);
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Phase: 0 = waiting for input, 1 = substituting, 2 = result offered.
  int           m_ph = 0;
  int           m_g = 0;
  logic [127:0] m_in = '0;
  bit           m_zero = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ph = 0; m_g = 0; m_in = '0; m_zero = 1'b1;
    end else begin
      case (m_ph)
        0: if (in_valid) begin m_in = in_data; m_g = 0; m_zero = 1'b0; m_ph = 1; end
        1: begin m_g++; if (m_g == NG) m_ph = 2; end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_bit("in_ready", in_ready, m_ph == 0);
      check_bit("out_valid", out_valid, m_ph == 2);
      check_vec("out_data", out_data, m_zero ? 128'h0 : partial(m_in, m_g));
    end
  end

  // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d);
    int t;
    in_valid = 1'b1; in_data = d; t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_in_ready expected=in_ready");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = rand128();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) begin
      checks++; failures++;
      $display("FAIL wait_out_timeout actual=no_out_valid expected=out_valid");
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, c1, t;
    logic [127:0] d, e, a, b, snap;

    build_tables();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_data", out_data, 128'h0);

    // Single-byte values pinned by hand.
    send(128'h52525252_52525252_52525252_00167c63);
    wait_out(lat);
    check_int("single_latency", lat, NG);
    check_vec("single_bytes", out_data, 128'h48484848_48484848_48484848_52ff0100);
    take();

    // Round trip over every byte value through the forward S-box.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) begin
        d[i*8 +: 8] = fwd_tab[j*16 + i];
        e[i*8 +: 8] = 8'(j*16 + i);
      end
      send(d);
      wait_out(lat);
      check_int("roundtrip_latency", lat, NG);
      check_vec("roundtrip_data", out_data, e);
      take();
    end

    // Backpressure in DONE.
    send(rand128());
    wait_out(lat);
    snap = out_data;
    repeat (10) begin
      @(negedge clk);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_vec("bp_stable", out_data, snap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit("bp_release_in_ready", in_ready, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    a = rand128(); b = rand128();
    out_ready = 1'b1; in_valid = 1'b1; in_data = a;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    c0 = cyc;
    @(negedge clk);
    in_data = b;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    c1 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check_int("b2b_accept_gap", c1 - c0, NG + 2);
    wait_out(lat);
    check_vec("b2b_second_result", out_data, inv_block(b));
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second BUSY cycle aborts the block.
    send(rand128());
    if (NG > 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_vec("abort_out_data", out_data, 128'h0);
    repeat (NG + 3) begin
      @(negedge clk);
      check_bit("abort_no_out_valid", out_valid, 1'b0);
    end
    d = rand128();
    send(d);
    wait_out(lat);
    check_int("after_abort_latency", lat, NG);
    check_vec("after_abort_data", out_data, inv_block(d));
    take();

    // Free-running random traffic, including inputs driven outside IDLE/DONE
    // and occasional resets; the model checks every cycle.
    repeat (800) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand128();
      out_ready = $urandom_range(0, 1) == 1;
      rst_n     = ($urandom_range(0, 63) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (NG + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
